// File: rtl/mont_exp_pkg.sv
// rtl/mont_exp_pkg.sv - shared field constants and FSM state type for mont_exp
package mont_exp_pkg;

  localparam int OP_W = 255;

  // N = 2^255 - 19
  localparam logic [OP_W-1:0] N        = {{(OP_W-5){1'b1}}, 5'b01101};
  localparam logic [OP_W-1:0] R_MOD_N  = OP_W'(19);
  localparam logic [OP_W-1:0] R2_MOD_N = OP_W'(361);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TO_MONT,
    S_SQR,
    S_MUL,
    S_FROM_MONT,
    S_DONE
  } state_t;

endpackage

// File: rtl/mont_exp.sv
// rtl/mont_exp.sv - square-and-multiply exponentiation controller driving a Montgomery multiplier
// MONT_CONV_EN: when defined, base/result are plain residues and conversion steps run.
module mont_exp
  import mont_exp_pkg::*;
#(
  parameter int EXP_W = OP_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [EXP_W-1:0] i_base,
  input  logic [EXP_W-1:0] i_exp,
  output logic             o_busy,
  output logic             o_done,
  output logic [EXP_W-1:0] o_result,
  output logic             o_mm_start,
  output logic [EXP_W-1:0] o_mm_a,
  output logic [EXP_W-1:0] o_mm_b,
  input  logic [EXP_W-1:0] i_mm_result,
  input  logic             i_mm_finished
);

  localparam int IDX_W = $clog2(EXP_W);

  state_t           state, state_n;
  logic [EXP_W-1:0] exp_r, base_m, acc;
  logic [IDX_W-1:0] idx;
  logic             fin_ok, accept, issue, capture, finish, step_exit;
  logic [EXP_W-1:0] op_a, op_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    step_exit = 1'b0;
    op_a      = acc;
    op_b      = acc;
    // A finish pulse in the same cycle as our start cannot belong to that operation.
    fin_ok    = i_mm_finished && !o_mm_start;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          accept = 1'b1;
          issue  = 1'b1;
`ifdef MONT_CONV_EN
          state_n = S_TO_MONT;
          op_a    = i_base;
          op_b    = R2_MOD_N;
`else
          state_n = S_SQR;
          op_a    = R_MOD_N;
          op_b    = R_MOD_N;
`endif
        end
      end
`ifdef MONT_CONV_EN
      S_TO_MONT: begin
        if (fin_ok) begin
          capture = 1'b1;
          issue   = 1'b1;
          state_n = S_SQR;
        end
      end
      S_FROM_MONT: begin
        if (fin_ok) begin
          capture = 1'b1;
          finish  = 1'b1;
          state_n = S_DONE;
        end
      end
`endif
      S_SQR: begin
        if (fin_ok) begin
          capture = 1'b1;
          if (exp_r[idx]) begin
            issue   = 1'b1;
            state_n = S_MUL;
            op_a    = i_mm_result;
            op_b    = base_m;
          end else if (idx == '0) begin
            step_exit = 1'b1;
          end else begin
            issue   = 1'b1;
            op_a    = i_mm_result;
            op_b    = i_mm_result;
          end
        end
      end
      S_MUL: begin
        if (fin_ok) begin
          capture = 1'b1;
          if (idx == '0) begin
            step_exit = 1'b1;
          end else begin
            issue   = 1'b1;
            state_n = S_SQR;
            op_a    = i_mm_result;
            op_b    = i_mm_result;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (step_exit) begin
`ifdef MONT_CONV_EN
      issue   = 1'b1;
      state_n = S_FROM_MONT;
      op_a    = i_mm_result;
      op_b    = EXP_W'(1);
`else
      finish  = 1'b1;
      state_n = S_DONE;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_r      <= '0;
      base_m     <= '0;
      acc        <= '0;
      idx        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_result   <= '0;
      o_mm_start <= 1'b0;
      o_mm_a     <= '0;
      o_mm_b     <= '0;
    end else begin
      o_mm_start <= issue;
      o_done     <= finish;
      if (issue) begin
        o_mm_a <= op_a;
        o_mm_b <= op_b;
      end
      if (accept) begin
        exp_r  <= i_exp;
        acc    <= R_MOD_N;
        idx    <= IDX_W'(EXP_W - 1);
        o_busy <= 1'b1;
`ifndef MONT_CONV_EN
        base_m <= i_base;
`endif
      end
      if (capture) begin
        if (state == S_TO_MONT) base_m <= i_mm_result;
        if (state == S_SQR || state == S_MUL) begin
          acc <= i_mm_result;
          if (state_n == S_SQR) idx <= idx - IDX_W'(1);
        end
      end
      if (finish) begin
        o_result <= i_mm_result;
        o_busy   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mont_exp.sv
// tb/tb_mont_exp.sv - directed-vector bench for mont_exp with a behavioural Montgomery multiplier
module tb_mont_exp;
  import mont_exp_pkg::*;

  localparam int LAT = 3;
`ifdef MONT_CONV_EN
  localparam int CONV_OPS = 2;
`else
  localparam int CONV_OPS = 0;
`endif

  typedef logic [254:0] word_t;
  typedef struct {
    word_t base;
    word_t exp;
    word_t res;
    int    ops;
  } vec_t;

  logic  i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0;
  word_t i_base = '0, i_exp = '0;
  logic  o_busy, o_done, o_mm_start;
  word_t o_result, o_mm_a, o_mm_b;
  word_t mdl_res = '0, ra = '0, rb = '0;
  logic  mdl_fin = 1'b0, spur = 1'b0, fin_q = 1'b0;
  bit    proto_err = 1'b0;
  int    checks = 0, errors = 0, starts = 0, cnt = 0;

  mont_exp dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_base       (i_base),
    .i_exp        (i_exp),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_result     (o_result),
    .o_mm_start   (o_mm_start),
    .o_mm_a       (o_mm_a),
    .o_mm_b       (o_mm_b),
    .i_mm_result  (mdl_res),
    .i_mm_finished(mdl_fin | spur)
  );

  always #5 i_clk = ~i_clk;

  // a*b*2^-255 mod N, bit-serial reduction
  function automatic word_t mont(input word_t a, input word_t b);
    logic [256:0] t;
    t = '0;
    for (int i = 0; i < 255; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, N};
      t = t >> 1;
    end
    if (t >= {2'b00, N}) t = t - {2'b00, N};
    return t[254:0];
  endfunction

  function automatic word_t to_in(input word_t b);
`ifdef MONT_CONV_EN
    return b;
`else
    return mont(b, R2_MOD_N);
`endif
  endfunction

  function automatic word_t from_out(input word_t r);
`ifdef MONT_CONV_EN
    return r;
`else
    return mont(r, word_t'(1));
`endif
  endfunction

  always @(negedge i_clk) begin
    mdl_fin = 1'b0;
    if (!i_rst_n) begin
      cnt = 0;
    end else begin
      if (cnt != 0) begin
        if (o_mm_start || o_mm_a !== ra || o_mm_b !== rb) proto_err = 1'b1;
        cnt--;
        if (cnt == 0) begin
          mdl_fin = 1'b1;
          mdl_res = mont(ra, rb);
        end
      end
      if (o_mm_start) begin
        starts++;
        ra  = o_mm_a;
        rb  = o_mm_b;
        cnt = LAT;
      end
    end
  end

  always @(posedge i_clk) fin_q <= mdl_fin;

  task automatic chk(input string nm, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic run(input word_t b, input word_t e, input int extra,
                     output word_t r, output int ns);
    int n;
    @(negedge i_clk);
    i_base    = b;
    i_exp     = e;
    i_start   = 1'b1;
    starts    = 0;
    proto_err = 1'b0;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    chk_b("accept_busy", o_busy, 1'b1);
    chk_b("accept_mm_start", o_mm_start, 1'b1);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
      i_start = (n == extra);
    end while (!o_done && n < 20000);
    i_start = 1'b0;
    chk_b("done_seen", o_done, 1'b1);
    chk_b("done_busy_low", o_busy, 1'b0);
    chk_b("done_after_fin", fin_q, 1'b1);
    r  = o_result;
    ns = starts;
    @(negedge i_clk);
    chk_b("done_one_cycle", o_done, 1'b0);
    chk_b("protocol_ok", proto_err, 1'b0);
  endtask

  vec_t  vecs[6];
  word_t r, prev, p, all1;
  int    ns, prev_starts;

  initial begin
    all1 = '1;
    vecs[0] = '{word_t'(7), word_t'(2),  word_t'(49),   256};
    vecs[1] = '{word_t'(5), word_t'(0),  word_t'(1),    255};
    vecs[2] = '{word_t'(2), word_t'(10), word_t'(1024), 257};
    vecs[3] = '{word_t'(0), word_t'(5),  word_t'(0),    257};
    vecs[4] = '{word_t'(1), all1,        word_t'(1),    510};
    vecs[5] = '{N - word_t'(1), word_t'(3), N - word_t'(1), 257};

    repeat (3) @(negedge i_clk);
    chk_b("rst_busy", o_busy, 1'b0);
    chk_b("rst_done", o_done, 1'b0);
    chk_b("rst_mm_start", o_mm_start, 1'b0);
    chk("rst_result", o_result, '0);
    chk("rst_mm_a", o_mm_a, '0);
    chk("rst_mm_b", o_mm_b, '0);
    i_rst_n = 1'b1;

    // vec0 also carries a stray start ten cycles into the run
    for (int i = 0; i < 6; i++) begin
      run(to_in(vecs[i].base), vecs[i].exp, (i == 0) ? 10 : 0, r, ns);
      chk($sformatf("vec%0d_result", i), from_out(r), vecs[i].res);
      chk($sformatf("vec%0d_starts", i), word_t'(ns), word_t'(vecs[i].ops + CONV_OPS));
    end

    prev        = o_result;
    prev_starts = starts;
    @(negedge i_clk);
    spur = 1'b1;
    @(negedge i_clk);
    spur = 1'b0;
    chk("spur_result", o_result, prev);
    chk_b("spur_busy", o_busy, 1'b0);
    chk_b("spur_done", o_done, 1'b0);
    chk_b("spur_mm_start", o_mm_start, 1'b0);
    repeat (2) @(negedge i_clk);
    chk("spur_starts", word_t'(starts), word_t'(prev_starts));

    run(to_in(word_t'(3)), N - word_t'(2), 0, r, ns);
    p = from_out(r);
    chk("inv_product", mont(mont(p, word_t'(3)), R2_MOD_N), word_t'(1));
    chk("inv_starts", word_t'(ns), word_t'(508 + CONV_OPS));

`ifndef MONT_CONV_EN
    run(word_t'(19), word_t'(8'h5A), 0, r, ns);
    chk("raw_one_result", r, word_t'(19));
    chk("raw_one_starts", word_t'(ns), word_t'(259));
`endif

    @(negedge i_clk);
    i_base  = to_in(word_t'(5));
    i_exp   = word_t'(3);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (40) @(negedge i_clk);
    chk_b("pre_abort_busy", o_busy, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_b("abort_busy", o_busy, 1'b0);
    chk_b("abort_done", o_done, 1'b0);
    chk_b("abort_mm_start", o_mm_start, 1'b0);
    chk("abort_result", o_result, '0);
    chk("abort_mm_a", o_mm_a, '0);
    chk("abort_mm_b", o_mm_b, '0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    run(to_in(word_t'(2)), word_t'(10), 0, r, ns);
    chk("restart_result", from_out(r), word_t'(1024));
    chk("restart_starts", word_t'(ns), word_t'(257 + CONV_OPS));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
